// File: rtl/johnson_phase_decoder_if.sv
// Sample/result bundle between a Johnson-code source and its phase decoder.
// Source drives code/en/clr_err; the decoder returns registered phase and status.
interface johnson_phase_decoder_if #(
    parameter int N     = 4,
    parameter int REV_W = 16
);
    localparam int W = $clog2(2 * N);

    logic             en;
    logic [N-1:0]     code;
    logic             clr_err;
    logic [2*N-1:0]   phase_onehot;
    logic [W-1:0]     phase_idx;
    logic             locked;
    logic             err_illegal;
    logic             err_step;
    logic             rev_pulse;
    logic [REV_W-1:0] rev_count;

    modport master (
        output en, code, clr_err,
        input  phase_onehot, phase_idx, locked, err_illegal, err_step, rev_pulse, rev_count
    );

    modport slave (
        input  en, code, clr_err,
        output phase_onehot, phase_idx, locked, err_illegal, err_step, rev_pulse, rev_count
    );
endinterface

// File: rtl/johnson_phase_decoder.sv
// Decodes a Johnson counter into a phase index, counts revolutions, flags bad codes.
// One-cycle latency, all outputs registered; no backpressure, en=0 freezes everything.
module johnson_phase_decoder #(
    parameter int N     = 4,
    parameter int REV_W = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    johnson_phase_decoder_if.slave  bus
);
    localparam int S = 2 * N;
    localparam int W = $clog2(S);
    localparam logic [W-1:0] LAST_IDX = W'(S - 1);

    typedef enum logic [1:0] {
        SYNC   = 2'd0,
        LOCKED = 2'd1,
        ERROR  = 2'd2
    } state_t;

    state_t           state, state_n;
    logic [W-1:0]     idx_r, idx_n;
    logic             ei_r, ei_n;
    logic             es_r, es_n;
    logic             rp_r, rp_n;
    logic [REV_W-1:0] cnt_r, cnt_n;
    logic             locked_r, locked_n;
    logic [S-1:0]     onehot_r, onehot_n;

    logic             code_legal;
    logic [W-1:0]     code_idx;
    logic [W-1:0]     succ_idx;

    // Index k<=N: k ones in the LSBs; k>N: all ones with k-N LSBs cleared.
    function automatic logic [N-1:0] johnson_pattern(input int k);
        logic [N-1:0] ones;
        ones = '1;
        if (k <= N)
            return ~(ones << k);
        else
            return ones << (k - N);
    endfunction

    always_comb begin
        code_legal = 1'b0;
        code_idx   = '0;
        for (int k = 0; k < S; k++) begin
            if (bus.code == johnson_pattern(k)) begin
                code_legal = 1'b1;
                code_idx   = W'(k);
            end
        end
    end

    assign succ_idx = (idx_r == LAST_IDX) ? '0 : idx_r + 1'b1;

    always_comb begin
        state_n = state;
        idx_n   = idx_r;
        ei_n    = ei_r;
        es_n    = es_r;
        rp_n    = 1'b0;
        cnt_n   = cnt_r;
        if (bus.en) begin
            // Clear first so an error detected in the same cycle still sets its flag.
            if (bus.clr_err) begin
                ei_n = 1'b0;
                es_n = 1'b0;
            end
            unique case (state)
                SYNC: begin
                    if (code_legal) begin
                        state_n = LOCKED;
                        idx_n   = code_idx;
                    end else begin
                        ei_n = 1'b1;
                    end
                end
                LOCKED: begin
                    if (!code_legal) begin
                        ei_n    = 1'b1;
                        state_n = ERROR;
                    end else if (code_idx != idx_r) begin
                        idx_n = code_idx;
                        if (code_idx == succ_idx) begin
                            if (idx_r == LAST_IDX) begin
                                rp_n  = 1'b1;
                                cnt_n = cnt_r + 1'b1;
                            end
                        end else begin
                            es_n = 1'b1;
                        end
                    end
                end
                ERROR: begin
                    if (bus.clr_err)
                        state_n = SYNC;
                end
                default: state_n = SYNC;
            endcase
        end
    end

    assign locked_n = (state_n == LOCKED);
    assign onehot_n = locked_n ? ({{(S-1){1'b0}}, 1'b1} << idx_n) : '0;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= SYNC;
            idx_r    <= '0;
            ei_r     <= 1'b0;
            es_r     <= 1'b0;
            rp_r     <= 1'b0;
            cnt_r    <= '0;
            locked_r <= 1'b0;
            onehot_r <= '0;
        end else begin
            state    <= state_n;
            idx_r    <= idx_n;
            ei_r     <= ei_n;
            es_r     <= es_n;
            rp_r     <= rp_n;
            cnt_r    <= cnt_n;
            locked_r <= locked_n;
            onehot_r <= onehot_n;
        end
    end

    assign bus.phase_onehot = onehot_r;
    assign bus.phase_idx    = idx_r;
    assign bus.locked       = locked_r;
    assign bus.err_illegal  = ei_r;
    assign bus.err_step     = es_r;
    assign bus.rev_pulse    = rp_r;
    assign bus.rev_count    = cnt_r;
endmodule

// File: doc/johnson_phase_decoder.md
JOHNSON_PHASE_DECODER -- requirements
Module: johnson_phase_decoder

Interface
REQ-001 Parameter N, default 4, meaning Johnson code width (≥2); the code has 2N legal states.
REQ-002 Parameter REV_W, default 16, meaning revolution counter width.
REQ-003 Local width W SHALL be clog2(2N).
REQ-004 clk  input  1  rising-edge clock, shared with the upstream johnson_counter.
REQ-005 rst  input  1  reset, synchronous, active-low.
REQ-006 en  input  1  sample enable; low SHALL freeze all state and outputs.
REQ-007 code  input  N  Johnson code from the upstream johnson_counter q.
REQ-008 clr_err  input  1  one-cycle pulse clearing sticky errors and leaving ERROR.
REQ-009 phase_onehot  output  2N  one-hot decoded phase; all-zero when not locked.
REQ-010 phase_idx  output  W  binary phase index 0..2N-1.
REQ-011 locked  output  1  high while the FSM is in LOCKED.
REQ-012 err_illegal  output  1  sticky: a non-Johnson code was sampled.
REQ-013 err_step  output  1  sticky: a legal code that is neither hold nor successor was sampled while locked.
REQ-014 rev_pulse  output  1  one-cycle pulse on each completed revolution.
REQ-015 rev_count  output  REV_W  revolution count, modulo 2^REV_W.

Function
REQ-016 Legal sequence SHALL be: index k≤N has k ones in the LSBs; index k>N is all ones with k-N LSBs zero (N=4: 0000,0001,0011,0111,1111,1110,1100,1000).
REQ-017 All outputs SHALL be registered; code sampled at edge t SHALL be reflected after edge t (1-cycle latency).
REQ-018 FSM states SHALL be SYNC, LOCKED and ERROR.
REQ-019 SYNC: on a legal code, go to LOCKED and load phase_idx; on an illegal code, set err_illegal and stay in SYNC.
REQ-020 LOCKED, code equals current phase (hold): no change.
REQ-021 LOCKED, code equals successor (idx+1 mod 2N): update idx.
REQ-022 LOCKED, idx 2N-1 to 0 transition: rev_pulse=1 for one cycle and rev_count+1, wrapping at 2^REV_W.
REQ-023 LOCKED, any other legal code: set err_step, load the new idx, stay in LOCKED, no rev_pulse.
REQ-024 LOCKED, illegal code: set err_illegal, go to ERROR.
REQ-025 ERROR: locked=0, phase_onehot=0 and phase_idx held; stay until clr_err=1, then go to SYNC.
REQ-026 clr_err SHALL clear err_illegal and err_step; a new error in the same cycle SHALL win (flag set).
REQ-027 In LOCKED, phase_onehot SHALL equal 1<<phase_idx.
REQ-028 en=0 SHALL take priority over all events except reset; rev_pulse SHALL be 0 while en=0.

Reset
REQ-029 rst=0 at a rising edge SHALL force SYNC and zero every output, including rev_count and the sticky flags; this SHALL apply mid-operation and SHALL override en and clr_err.
REQ-030 After rst returns high, the first legal code SHALL lock on the next edge.

Verification
REQ-031 Reset: rst=0 for 2 cycles with code=0101, en=1 -> all outputs 0, locked=0.
REQ-032 Full sequence: after reset, en=1, feed 0000..1000 twice, one code per cycle -> locked=1 after the first edge; phase_idx steps 0..7; rev_pulse on each 7->0; rev_count=1 after the first wrap.
REQ-033 Illegal code: locked at idx 2, code=0101 -> err_illegal=1, locked=0, phase_onehot=0. Then clr_err pulse -> SYNC. Then code=0011 -> locked=1, phase_idx=2, err_illegal=0.
REQ-034 Skip: locked at 0001, code=0111 -> err_step=1, phase_idx=3, locked=1, rev_count unchanged.
REQ-035 Hold and freeze: code=0011 held 5 cycles -> idx 2, no errors, no rev_pulse. Then en=0 with code=1111 -> outputs unchanged.
REQ-036 Mid-run reset: rev_count=2, err_step=1, rst=0 for one edge -> all outputs 0, state SYNC.
